// File: rtl/counter_sequencer.sv
// counter_sequencer: sequences a WIDTH-bit up-counter through IDLE/RUN/DONE.
// Supports a programmable terminal count, one-shot or auto-reload runs,
// and a done/ack handshake with the host.
//
// Handshake: the host raises start in IDLE to begin a run. In one-shot mode
// the block raises done, and done stays high until the host returns done_ack.
// The host sees done_ack take effect at the next rising edge, and must
// present a new start in IDLE to run again.
module counter_sequencer #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TERM_RST = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] term,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             done_ack,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_term;
  logic             r_busy;
  logic             r_done;
  logic             r_tick;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_term_nxt;
  logic             w_tick_nxt;

  // Next-state, next-count, terminal-register and tick decisions
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_term_nxt  = r_term;
    w_tick_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The term write and the run start share this edge, so a run
        // started together with a write compares against the new term.
        if (cfg_we) begin
          w_term_nxt = term;
        end
        if (start) begin
          w_state_nxt = ST_RUN;
          w_q_nxt     = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (en) begin
          if (r_q != r_term) begin
            w_q_nxt = r_q + WIDTH'(1);
          end else if (auto_reload) begin
            w_q_nxt    = '0;
            w_tick_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A start that arrives with done_ack is dropped.
        if (done_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, count, terminal register and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_term  <= TERM_RST;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_term  <= w_term_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      r_tick  <= w_tick_nxt;
    end
  end

  assign q         = r_q;
  assign busy      = r_busy;
  assign done      = r_done;
  assign tick      = r_tick;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer. Each step pushes the hand-derived
// expected {q, busy, done, tick} for the coming edge and compares it after
// that edge.
module tb_counter_sequencer;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 3;

  logic             clk;
  logic             reset;
  logic             cfg_we;
  logic [WIDTH-1:0] term;
  logic             auto_reload;
  logic             start;
  logic             stop;
  logic             en;
  logic             done_ack;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             tick;
  logic [1:0]       dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  counter_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .term        (term),
    .auto_reload (auto_reload),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .done_ack    (done_ack),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .tick        (tick),
    .dbg_state   (dbg_state)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed q=%0d busy=%0b done=%0b tick=%0b, expected q=%0d busy=%0b done=%0b tick=%0b",
             tag, obs[W-1:3], obs[2], obs[1], obs[0], expv[W-1:3], expv[2], expv[1], expv[0]);
    end
  endtask

  // Push the expectation, run one edge, then pop and compare.
  task automatic step(input string tag, input int eq, input logic eb, input logic ed, input logic et);
    logic [W-1:0] e;
    exp_q.push_back({eq[WIDTH-1:0], eb, ed, et});
    cyc();
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {q, busy, done, tick}, e);
    end
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; term = '0; auto_reload = 1'b0;
    start = 1'b0; stop = 1'b0; en = 1'b0; done_ack = 1'b0;
    cyc(); cyc();
    check("reset_init", {q, busy, done, tick}, {4'd0, 3'b000});
    reset = 1'b1;

    // Test 1: run to q=5 on the reset term, then assert reset between edges
    start = 1'b1; en = 1'b1;
    step("t1_start", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) step("t1_count", i, 1, 0, 0);
    #2 reset = 1'b0;
    #1 check("t1_async_reset", {q, busy, done, tick}, {4'd0, 3'b000});
    cyc();
    reset = 1'b1;
    // The terminal register is back to all ones: the run visits 0..15
    start = 1'b1;
    step("t1_rerun_start", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 15; i++) step("t1_full_count", i, 1, 0, 0);
    step("t1_done_at_15", 15, 0, 1, 0);
    done_ack = 1'b1;
    step("t1_ack", 15, 0, 0, 0);
    done_ack = 1'b0;

    // Test 2: one-shot with term=3
    cfg_we = 1'b1; term = 4'd3;
    step("t2_cfg_idle", 15, 0, 0, 0);
    cfg_we = 1'b0; start = 1'b1; en = 1'b1; auto_reload = 1'b0;
    step("t2_start", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step("t2_count", i, 1, 0, 0);
    step("t2_done", 3, 0, 1, 0);
    step("t2_done_hold", 3, 0, 1, 0);
    done_ack = 1'b1;
    step("t2_ack", 3, 0, 0, 0);
    done_ack = 1'b0;

    // Test 3: auto-reload with term=2, written in the same cycle as start
    cfg_we = 1'b1; term = 4'd2; auto_reload = 1'b1; start = 1'b1; en = 1'b1;
    step("t3_start", 0, 1, 0, 0);
    cfg_we = 1'b0; start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step("t3_q1", 1, 1, 0, 0);
      step("t3_q2", 2, 1, 0, 0);
      step("t3_wrap_tick", 0, 1, 0, 1);
    end
    stop = 1'b1;
    step("t3_stop", 0, 0, 0, 0);
    stop = 1'b0;

    // Test 4: enable gating, then stop on the terminal cycle
    cfg_we = 1'b1; term = 4'd5; auto_reload = 1'b0; start = 1'b1; en = 1'b1;
    step("t4_start", 0, 1, 0, 0);
    cfg_we = 1'b0; start = 1'b0;
    en = 1'b1; step("t4_en1", 1, 1, 0, 0);
    en = 1'b0; step("t4_en0", 1, 1, 0, 0);
    en = 1'b1; step("t4_en1b", 2, 1, 0, 0);
    en = 1'b0; step("t4_en0b", 2, 1, 0, 0);
    en = 1'b1;
    for (int i = 3; i <= 5; i++) step("t4_count", i, 1, 0, 0);
    stop = 1'b1;
    step("t4_stop_at_term", 5, 0, 0, 0);
    stop = 1'b0;
    step("t4_idle_hold", 5, 0, 0, 0);

    // Test 5: cfg_we and start in RUN are ignored; start with done_ack is dropped
    start = 1'b1;
    step("t5_start", 0, 1, 0, 0);
    start = 1'b0; cfg_we = 1'b1; term = 4'd7;
    step("t5_cfg_in_run", 1, 1, 0, 0);
    cfg_we = 1'b0; start = 1'b1;
    step("t5_start_in_run", 2, 1, 0, 0);
    start = 1'b0;
    for (int i = 3; i <= 5; i++) step("t5_count", i, 1, 0, 0);
    step("t5_done_term5", 5, 0, 1, 0);
    stop = 1'b1;
    step("t5_stop_in_done", 5, 0, 1, 0);
    stop = 1'b0; done_ack = 1'b1; start = 1'b1;
    step("t5_ack_with_start", 5, 0, 0, 0);
    done_ack = 1'b0; start = 1'b0;
    step("t5_still_idle", 5, 0, 0, 0);
    start = 1'b1;
    step("t5_second_start", 0, 1, 0, 0);
    start = 1'b0; stop = 1'b1;
    step("t5_stop", 0, 0, 0, 0);
    stop = 1'b0;

    // Test 6: term=0, one-shot then auto-reload
    cfg_we = 1'b1; term = 4'd0; auto_reload = 1'b0; start = 1'b1; en = 1'b1;
    step("t6_start_oneshot", 0, 1, 0, 0);
    cfg_we = 1'b0; start = 1'b0;
    step("t6_done_first", 0, 0, 1, 0);
    done_ack = 1'b1;
    step("t6_ack", 0, 0, 0, 0);
    done_ack = 1'b0; auto_reload = 1'b1; start = 1'b1;
    step("t6_start_auto", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) step("t6_tick_every", 0, 1, 0, 1);
    en = 1'b0;
    step("t6_en_off", 0, 1, 0, 0);
    stop = 1'b1;
    step("t6_stop", 0, 0, 0, 0);
    stop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
